// File: rtl/parity_rr_sched_pkg.sv
// Shared definitions for the parity round-robin scheduler.
//   state_t  : scheduler FSM encoding (IDLE/ACCUM/RESULT)
//   *_DEF    : default geometry constants
package parity_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned SIZE_DEF  = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned ID_W_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/parity_rr_sched_if.sv
// Request/result bundle of the parity round-robin scheduler.
//   req_valid/req_data/req_last : per-requester word stream (source -> scheduler)
//   req_ready                   : per-requester accept, at most one bit set
//   odd_mode                    : 1 = odd parity, sampled at grant
//   res_valid/res_ready         : result handshake
//   res_parity/res_id/res_count : registered packet result
//   busy                        : scheduler in ACCUM or RESULT
// master = packet sources + result sink, slave = scheduler.
interface parity_rr_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned SIZE  = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ID_W  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*SIZE-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 odd_mode;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_parity;
  logic [ID_W-1:0]      res_id;
  logic [CNT_W-1:0]     res_count;
  logic                 busy;

  modport master (
    output req_valid, req_data, req_last, odd_mode, res_ready,
    input  req_ready, res_valid, res_parity, res_id, res_count, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, odd_mode, res_ready,
    output req_ready, res_valid, res_parity, res_id, res_count, busy
  );
endinterface

// File: rtl/parity_rr_sched_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index; search runs ptr, ptr+1, ... modulo NREQ
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted request (0 when no request)
module rr_pick
  import parity_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned ID_W = ID_W_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);

  logic found;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned c;
      c = (32'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = ID_W'(c);
      end
    end
    gnt = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      gnt[j] = found && (ID_W'(j) == idx);
    end
  end

endmodule

// File: rtl/parity_rr_sched.sv
// Round-robin scheduler sharing one XOR-reduction parity unit between
// NREQ packet sources. One packet is granted at a time; parity is
// accumulated over all its words and a registered result (parity,
// requester id, saturating word count) is presented after the last word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side)
module parity_rr_sched
  import parity_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned SIZE  = SIZE_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity_rr_sched_if.slave      bus
);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             odd_q;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  ready_q;
  logic             res_valid_q;
  logic             res_parity_q;
  logic [ID_W-1:0]  res_id_q;
  logic [CNT_W-1:0] res_count_q;
  logic             busy_q;

  logic [NREQ-1:0]  pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic [SIZE-1:0]  word;
  logic             word_par;
  logic             hs;
  logic             hs_last;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ID_W-1:0]  ptr_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // ready_q is one-hot on the granted requester during ACCUM, so masking
  // valid/last with it isolates the granted stream.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == grant_id) word = bus.req_data[i*SIZE +: SIZE];
    end
    word_par = ^word;
    hs       = |(bus.req_valid & ready_q);
    hs_last  = |(bus.req_valid & bus.req_last & ready_q);
    cnt_nxt  = (cnt == '1) ? cnt : cnt + 1'b1;
    ptr_nxt  = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      odd_q        <= 1'b0;
      acc          <= 1'b0;
      cnt          <= '0;
      ready_q      <= '0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= '0;
      res_count_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_id <= pick_idx;
            odd_q    <= bus.odd_mode;
            acc      <= 1'b0;
            cnt      <= '0;
            ready_q  <= pick_gnt;
            busy_q   <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (hs) begin
            acc <= acc ^ word_par;
            cnt <= cnt_nxt;
            if (hs_last) begin
              res_parity_q <= acc ^ word_par ^ odd_q;
              res_count_q  <= cnt_nxt;
              res_id_q     <= grant_id;
              res_valid_q  <= 1'b1;
              ready_q      <= '0;
              state        <= RESULT;
            end
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr      <= ptr_nxt;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_parity = res_parity_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_count  = res_count_q;
  assign bus.busy       = busy_q;

endmodule
